ballot_controller: RTL and testbench

- Front-end stage of the voting machine; sits directly upstream of the per-candidate up-counters.
- Synchronizes and debounces the raw candidate push-buttons.
- Enforces one vote per officer-issued ballot authorization.
- Emits exactly one single-cycle count_in pulse to the chosen candidate's counter per valid ballot.

---
 rtl/ballot_controller.sv | 149 ++++++++++++++
 tb/tb_ballot_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_controller.sv
// Voting-machine front end: synchronizes and debounces candidate buttons, enforces
// one vote per ballot authorization and emits one count_in pulse per accepted vote.
module ballot_controller #(
  parameter int NUM_CAND        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCK_CYCLES     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ballot_enable,
  input  logic [NUM_CAND-1:0] cand_btn,
  output logic [NUM_CAND-1:0] count_in,
  output logic                ready,
  output logic                vote_done,
  output logic                invalid_vote
);

  localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LK_W  = $clog2(LOCK_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, LOCK, RELEASE} state_t;

  // Handshake: none; ballot_enable is a level whose synchronized rising edge opens
  // one ballot, and count_in is a fire-and-forget one-cycle strobe to the counters.
  state_t              state, state_d;
  logic                en_meta, en_sync, en_prev;
  logic [NUM_CAND-1:0] btn_meta, btn_sync;
  logic [NUM_CAND-1:0] db, db_prev;
  logic [DB_W-1:0]     db_cnt [NUM_CAND];
  logic [IDX_W-1:0]    idx, idx_d, rise_idx;
  logic [LK_W-1:0]     lock_cnt, lock_cnt_d;
  logic                need_clear, need_clear_d;
  logic                invalid_d;
  logic [NUM_CAND-1:0] db_rise;
  logic                vote_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta  <= 1'b0;
      en_sync  <= 1'b0;
      en_prev  <= 1'b0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      en_meta  <= ballot_enable;
      en_sync  <= en_meta;
      en_prev  <= en_sync;
      btn_meta <= cand_btn;
      btn_sync <= btn_meta;
    end
  end

  // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < NUM_CAND; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db;
      for (int i = 0; i < NUM_CAND; i++) begin
        if (btn_sync[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= btn_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    db_rise  = db & ~db_prev;
    rise_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (db_rise[i]) rise_idx = IDX_W'(i);
    end
    // Single fresh press with nothing else held and no pending clear-out.
    vote_ok = (db_rise != '0) && ((db_rise & (db_rise - NUM_CAND'(1))) == '0) &&
              ((db & ~db_rise) == '0) && !need_clear;
  end

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    lock_cnt_d   = lock_cnt;
    need_clear_d = need_clear;
    invalid_d    = 1'b0;
    case (state)
      IDLE: begin
        if (en_sync && !en_prev) begin
          state_d      = ARMED;
          need_clear_d = (db != '0);
        end
      end
      ARMED: begin
        if (need_clear && (db == '0)) need_clear_d = 1'b0;
        if (vote_ok) begin
          idx_d   = rise_idx;
          state_d = CAPTURE;
        end else if (db_rise != '0) begin
          invalid_d    = 1'b1;
          need_clear_d = 1'b1;
        end
      end
      CAPTURE: begin
        state_d    = LOCK;
        lock_cnt_d = '0;
      end
      LOCK: begin
        if (lock_cnt == LK_LAST) state_d = RELEASE;
        else lock_cnt_d = lock_cnt + LK_W'(1);
      end
      RELEASE: begin
        if (db == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      lock_cnt     <= '0;
      need_clear   <= 1'b0;
      count_in     <= '0;
      ready        <= 1'b0;
      vote_done    <= 1'b0;
      invalid_vote <= 1'b0;
    end else begin
      state        <= state_d;
      idx          <= idx_d;
      lock_cnt     <= lock_cnt_d;
      need_clear   <= need_clear_d;
      count_in     <= (state_d == CAPTURE) ? (NUM_CAND'(1) << idx_d) : '0;
      ready        <= (state_d == ARMED);
      vote_done    <= (state_d == LOCK) || (state_d == RELEASE);
      invalid_vote <= invalid_d;
    end
  end

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller: vote latency, debounce, multi-press,
// double-vote lockout, held-button guard and asynchronous reset mid-vote.
module tb_ballot_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ballot_enable;
  logic [3:0] cand_btn;
  logic [3:0] count_in;
  logic       ready;
  logic       vote_done;
  logic       invalid_vote;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  ballot_controller #(.NUM_CAND(4), .DEBOUNCE_CYCLES(4), .LOCK_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ballot_enable(ballot_enable),
    .cand_btn     (cand_btn),
    .count_in     (count_in),
    .ready        (ready),
    .vote_done    (vote_done),
    .invalid_vote (invalid_vote)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // invariants, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot0", 32'($onehot0(count_in)), 1);
      check("excl", 32'(ready & vote_done), 0);
      if (count_in != 0) pulses++;
    end
  end

  // driver tasks
  task automatic arm(input string tag);
    ballot_enable = 1'b0;
    repeat (3) @(negedge clk);
    ballot_enable = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_arm_early"}, 32'(ready), 0);
    @(negedge clk);
    check({tag, "_arm_ready"}, 32'(ready), 1);
  endtask

  task automatic press_expect(input logic [3:0] btn, input logic [3:0] exp, input string tag);
    int lat;
    logic [3:0] got;
    cand_btn = btn;
    lat = 0;
    got = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (count_in != 0) begin
        got = count_in;
        break;
      end
    end
    check({tag, "_val"}, 32'(got), 32'(exp));
    check({tag, "_lat"}, lat, 7);
    check({tag, "_ready_cap"}, 32'(ready), 0);
    @(negedge clk);
    check({tag, "_pulse1"}, 32'(count_in), 0);
    check({tag, "_vote_done"}, 32'(vote_done), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((vote_done || ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(vote_done | ready), 0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (count_in != 0 || invalid_vote) bad++;
    end
    check({tag, "_quiet"}, bad, 0);
  endtask

  initial begin
    int lat, bad;
    rst_n = 1'b0;
    ballot_enable = 1'b0;
    cand_btn = 4'b0000;
    #12;
    check("rst_count_in", 32'(count_in), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_vote_done", 32'(vote_done), 0);
    check("rst_invalid", 32'(invalid_vote), 0);
    #8 rst_n = 1'b1;
    @(negedge clk);

    // single vote for candidate 2
    arm("t1");
    press_expect(4'b0100, 4'b0100, "t1");
    repeat (2) @(negedge clk);
    cand_btn = 4'b0000;
    wait_idle("t1");

    // bounce rejection on candidate 1
    arm("t2");
    for (int i = 0; i < 8; i++) begin
      cand_btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      @(negedge clk);
    end
    cand_btn = 4'b0000;
    quiet(6, "t2_bounce");
    check("t2_ready_held", 32'(ready), 1);
    press_expect(4'b0010, 4'b0010, "t2");
    repeat (4) @(negedge clk);
    cand_btn = 4'b0000;
    wait_idle("t2");

    // multi-press then valid press
    arm("t3");
    cand_btn = 4'b0011;
    lat = 0;
    while (lat < 20 && !invalid_vote) begin
      @(negedge clk);
      lat++;
    end
    check("t3_invalid", 32'(invalid_vote), 1);
    check("t3_invalid_lat", lat, 7);
    check("t3_no_count", 32'(count_in), 0);
    check("t3_ready", 32'(ready), 1);
    @(negedge clk);
    check("t3_invalid_1cyc", 32'(invalid_vote), 0);
    repeat (3) @(negedge clk);
    cand_btn = 4'b0000;
    quiet(8, "t3_release");
    press_expect(4'b1000, 4'b1000, "t3");
    cand_btn = 4'b0000;
    wait_idle("t3");

    // double-vote prevention
    arm("t4");
    press_expect(4'b0001, 4'b0001, "t4");
    cand_btn = 4'b0111;
    ballot_enable = 1'b0;
    repeat (3) @(negedge clk);
    ballot_enable = 1'b1;
    quiet(14, "t4_lock");
    cand_btn = 4'b0000;
    wait_idle("t4");
    quiet(5, "t4_no_queue");
    check("t4_no_queue_ready", 32'(ready), 0);
    arm("t4b");
    press_expect(4'b0100, 4'b0100, "t4b");
    cand_btn = 4'b0000;
    wait_idle("t4b");

    // held-button guard
    ballot_enable = 1'b0;
    cand_btn = 4'b0100;
    repeat (8) @(negedge clk);
    arm("t5");
    quiet(10, "t5_held");
    check("t5_ready_held", 32'(ready), 1);
    cand_btn = 4'b0000;
    quiet(8, "t5_release");
    press_expect(4'b0100, 4'b0100, "t5");
    cand_btn = 4'b0000;
    wait_idle("t5");

    // asynchronous reset during CAPTURE
    arm("t6");
    cand_btn = 4'b1000;
    lat = 0;
    while (lat < 20 && count_in == 0) begin
      @(negedge clk);
      lat++;
    end
    check("t6_capture", 32'(count_in), 32'(4'b1000));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_count_in", 32'(count_in), 0);
    check("t6_rst_ready", 32'(ready), 0);
    check("t6_rst_vote_done", 32'(vote_done), 0);
    check("t6_rst_invalid", 32'(invalid_vote), 0);
    ballot_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (count_in != 0 || ready || vote_done) bad++;
    end
    check("t6_post_reset_idle", bad, 0);
    cand_btn = 4'b0000;
    repeat (8) @(negedge clk);
    arm("t6b");
    press_expect(4'b0001, 4'b0001, "t6b");
    cand_btn = 4'b0000;
    wait_idle("t6b");

    check("total_pulses", pulses, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
